vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Sequences every access to the shared 128K x 8 asynchronous video SRAM.
- Arbitrates between two requesters:
  - Video fetch: linear address, read-only, hard deadline, strict priority.
  - MPU interface: X/Y pixel coordinates, read or write.
- Converts coordinates to linear addresses, generates the SRAM strobes and owns the direction control of the bidirectional data bus.

Parameters:
- ACCESS_CYCLES, 2, clock cycles the strobe is held low per access (1..7).
- FB_WIDTH, 320, pixels per line; linear address = y*FB_WIDTH + x.
- FB_HEIGHT, 240, lines in the frame buffer.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- resetN  in  1  asynchronous active-low reset.
- videoRequest  in  1  one-cycle pulse requesting a read at videoAddress.
- videoAddress  in  17  linear SRAM address; sampled with videoRequest.
- videoData  out  8  read data; valid while videoDataReady is high.
- videoDataReady  out  1  one-cycle pulse, video read complete.
- videoOverrun  out  1  one-cycle pulse, video request lost (see below).
- memoryXCoord  in  9  MPU pixel X.
- memoryYCoord  in  8  MPU pixel Y.
- memoryReadRequest  in  1  level; held until memoryReadComplete.
- memoryWriteRequest  in  1  level; held until memoryWriteComplete.
- memoryWriteData  in  8  MPU write byte; stable while memoryWriteRequest is high.
- memoryReadData  out  8  MPU read byte; valid with memoryReadComplete and held until the next MPU read.
- memoryReadComplete  out  1  one-cycle pulse.
- memoryWriteComplete  out  1  one-cycle pulse.
- memoryRangeError  out  1  one-cycle pulse, coordinates out of range.
- ramAddress  out  17  SRAM address (registered).
- ramData  inout  8  SRAM data; driven only in WRITE and RECOVER.
- ramWriteEnable  out  1  active-low SRAM WE.
- ramOutputEnable  out  1  active-low SRAM OE.

Behaviour:
- Reset (asynchronous, immediate, including mid-access):
  - ramWriteEnable=1, ramOutputEnable=1, ramAddress=0, ramData=Z.
  - All pulse outputs 0; videoData=0, memoryReadData=0.
  - Pending-video latch cleared; state=IDLE.
- Video pending latch (one deep):
  - Set by videoRequest and captures videoAddress.
  - A videoRequest arriving while the latch is already full overwrites the address and pulses videoOverrun in the same cycle.
- States:
  - IDLE
  - VREAD
  - MREAD
  - MWRITE
  - RECOVER
  - DONE_ERR
- Grant in IDLE, priority order:
  1. Pending video (including a videoRequest arriving this cycle) -> VREAD.
  2. memoryWriteRequest -> MWRITE (write wins over a simultaneous read).
  3. memoryReadRequest -> MREAD.
- MPU address = (y<<8)+(y<<6)+x for the default width; general rule y*FB_WIDTH+x, 17-bit, no truncation.
  - x>=FB_WIDTH or y>=FB_HEIGHT -> DONE_ERR, with no SRAM strobe.
  - DONE_ERR pulses memoryRangeError plus the matching complete pulse; a read returns 0x00.
- Access timing, with the grant at edge k:
  - ramAddress is valid from edge k; the strobe is low for edges k .. k+ACCESS_CYCLES.
  - Reads: ramOutputEnable low; data sampled at edge k+ACCESS_CYCLES, when OE returns high.
  - The ready/complete pulse is high in the cycle after edge k+ACCESS_CYCLES.
  - Total latency from the grant edge to the pulse is ACCESS_CYCLES+1 edges.
- Writes:
  - ramWriteEnable low and ramData driven with memoryWriteData from edge k.
  - WE returns high at edge k+ACCESS_CYCLES, entering RECOVER.
  - RECOVER holds data one more cycle, releases ramData at its exit and pulses memoryWriteComplete.
  - No grant is made in RECOVER, which guarantees bus turnaround.
- After every access, return to IDLE; back-to-back grants are allowed (IDLE lasts one cycle).
- ramWriteEnable and ramOutputEnable are never low simultaneously.
- MPU request dropped mid-access: the access completes and the complete pulse still fires.
- Video is never delayed by more than one in-flight MPU access (worst case ACCESS_CYCLES+2 cycles).

Test Plan:
- videoRequest at address 0x00010, SRAM model holds 0xA5 -> with ACCESS_CYCLES=2, OE low for 2 cycles and videoDataReady with videoData=0xA5 three edges after the grant.
- MPU write x=5, y=3, data 0x3C -> ramAddress=965, WE low 2 cycles, data held 1 extra cycle, memoryWriteComplete pulse; a read-back gives memoryReadData=0x3C.
- memoryReadRequest and videoRequest in the same IDLE cycle -> video served first, MPU read granted immediately after; both correct.
- Coordinates x=320, y=0 (then x=0, y=240) -> no WE/OE activity, memoryRangeError plus the complete pulse; the read returns 0x00.
- Two videoRequests (0x100 then 0x200) while MWRITE is in flight -> videoOverrun pulses once and only 0x200 is read.
- resetN low mid-MWRITE -> WE/OE high and ramData Z immediately; after release, state is IDLE and no complete pulse is issued.

Source files
------------

// File: rtl/vram_arbiter.sv
// Arbiter and strobe sequencer for the shared 128K x 8 asynchronous video SRAM.
// Video fetch has strict priority; MPU X/Y accesses are mapped to linear addresses.
module vram_arbiter #(
   parameter int ACCESS_CYCLES = 2,
   parameter int FB_WIDTH      = 320,
   parameter int FB_HEIGHT     = 240
) (
   input  logic        clock,
   input  logic        resetN,
   input  logic        videoRequest,
   input  logic [16:0] videoAddress,
   output logic [7:0]  videoData,
   output logic        videoDataReady,
   output logic        videoOverrun,
   input  logic [8:0]  memoryXCoord,
   input  logic [7:0]  memoryYCoord,
   input  logic        memoryReadRequest,
   input  logic        memoryWriteRequest,
   input  logic [7:0]  memoryWriteData,
   output logic [7:0]  memoryReadData,
   output logic        memoryReadComplete,
   output logic        memoryWriteComplete,
   output logic        memoryRangeError,
   output logic [16:0] ramAddress,
   inout  wire  [7:0]  ramData,
   output logic        ramWriteEnable,
   output logic        ramOutputEnable
);

   typedef enum logic [2:0] {
      IDLE,
      VREAD,
      MREAD,
      MWRITE,
      RECOVER,
      DONE_ERR
   } state_t;

   localparam logic [2:0]  CNT_INIT = 3'(ACCESS_CYCLES - 1);
   localparam logic [16:0] LINE_LEN = 17'(FB_WIDTH);

   state_t      state;
   logic [2:0]  count;
   logic        video_pending;
   logic [16:0] video_addr;
   logic [7:0]  write_data;
   logic        drive_en;
   logic        err_read;

   logic        video_want;
   logic [16:0] video_next;
   logic [16:0] mpu_addr;
   logic        mpu_bad;

   // A request arriving this cycle counts as pending and supersedes the latched address.
   always_comb begin
      video_want = videoRequest | video_pending;
      video_next = videoRequest ? videoAddress : video_addr;
      mpu_addr   = 17'(memoryYCoord) * LINE_LEN + 17'(memoryXCoord);
      mpu_bad    = (32'(memoryXCoord) >= FB_WIDTH) || (32'(memoryYCoord) >= FB_HEIGHT);
   end

   assign videoOverrun = videoRequest & video_pending;
   assign ramData      = drive_en ? write_data : 8'bz;

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state               <= IDLE;
         count               <= '0;
         video_pending       <= 1'b0;
         video_addr          <= '0;
         write_data          <= '0;
         drive_en            <= 1'b0;
         err_read            <= 1'b0;
         videoData           <= '0;
         videoDataReady      <= 1'b0;
         memoryReadData      <= '0;
         memoryReadComplete  <= 1'b0;
         memoryWriteComplete <= 1'b0;
         memoryRangeError    <= 1'b0;
         ramAddress          <= '0;
         ramWriteEnable      <= 1'b1;
         ramOutputEnable     <= 1'b1;
      end else begin
         videoDataReady      <= 1'b0;
         memoryReadComplete  <= 1'b0;
         memoryWriteComplete <= 1'b0;
         memoryRangeError    <= 1'b0;

         if (videoRequest) begin
            video_pending <= 1'b1;
            video_addr    <= videoAddress;
         end

         case (state)
            IDLE: begin
               if (video_want) begin
                  state           <= VREAD;
                  ramAddress      <= video_next;
                  ramOutputEnable <= 1'b0;
                  count           <= CNT_INIT;
                  video_pending   <= 1'b0;
               end else if (memoryWriteRequest) begin
                  if (mpu_bad) begin
                     state    <= DONE_ERR;
                     err_read <= 1'b0;
                  end else begin
                     state          <= MWRITE;
                     ramAddress     <= mpu_addr;
                     ramWriteEnable <= 1'b0;
                     write_data     <= memoryWriteData;
                     drive_en       <= 1'b1;
                     count          <= CNT_INIT;
                  end
               end else if (memoryReadRequest) begin
                  if (mpu_bad) begin
                     state    <= DONE_ERR;
                     err_read <= 1'b1;
                  end else begin
                     state           <= MREAD;
                     ramAddress      <= mpu_addr;
                     ramOutputEnable <= 1'b0;
                     count           <= CNT_INIT;
                  end
               end
            end

            VREAD: begin
               if (count == 3'd0) begin
                  videoData       <= ramData;
                  videoDataReady  <= 1'b1;
                  ramOutputEnable <= 1'b1;
                  state           <= IDLE;
               end else begin
                  count <= count - 3'd1;
               end
            end

            MREAD: begin
               if (count == 3'd0) begin
                  memoryReadData     <= ramData;
                  memoryReadComplete <= 1'b1;
                  ramOutputEnable    <= 1'b1;
                  state              <= IDLE;
               end else begin
                  count <= count - 3'd1;
               end
            end

            MWRITE: begin
               if (count == 3'd0) begin
                  ramWriteEnable <= 1'b1;
                  state          <= RECOVER;
               end else begin
                  count <= count - 3'd1;
               end
            end

            // Data is held one cycle past WE rising so the bus turns around cleanly.
            RECOVER: begin
               drive_en            <= 1'b0;
               memoryWriteComplete <= 1'b1;
               state               <= IDLE;
            end

            DONE_ERR: begin
               memoryRangeError <= 1'b1;
               if (err_read) begin
                  memoryReadComplete <= 1'b1;
                  memoryReadData     <= 8'h00;
               end else begin
                  memoryWriteComplete <= 1'b1;
               end
               state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural asynchronous SRAM model.
module tb_vram_arbiter;

   logic        clock;
   logic        resetN;
   logic        videoRequest;
   logic [16:0] videoAddress;
   logic [7:0]  videoData;
   logic        videoDataReady;
   logic        videoOverrun;
   logic [8:0]  memoryXCoord;
   logic [7:0]  memoryYCoord;
   logic        memoryReadRequest;
   logic        memoryWriteRequest;
   logic [7:0]  memoryWriteData;
   logic [7:0]  memoryReadData;
   logic        memoryReadComplete;
   logic        memoryWriteComplete;
   logic        memoryRangeError;
   logic [16:0] ramAddress;
   wire  [7:0]  ramData;
   logic        ramWriteEnable;
   logic        ramOutputEnable;

   int n_checks;
   int n_fail;

   logic [7:0] sram [0:131071];

   vram_arbiter #(.ACCESS_CYCLES(2), .FB_WIDTH(320), .FB_HEIGHT(240)) dut (
      .clock               (clock),
      .resetN              (resetN),
      .videoRequest        (videoRequest),
      .videoAddress        (videoAddress),
      .videoData           (videoData),
      .videoDataReady      (videoDataReady),
      .videoOverrun        (videoOverrun),
      .memoryXCoord        (memoryXCoord),
      .memoryYCoord        (memoryYCoord),
      .memoryReadRequest   (memoryReadRequest),
      .memoryWriteRequest  (memoryWriteRequest),
      .memoryWriteData     (memoryWriteData),
      .memoryReadData      (memoryReadData),
      .memoryReadComplete  (memoryReadComplete),
      .memoryWriteComplete (memoryWriteComplete),
      .memoryRangeError    (memoryRangeError),
      .ramAddress          (ramAddress),
      .ramData             (ramData),
      .ramWriteEnable      (ramWriteEnable),
      .ramOutputEnable     (ramOutputEnable)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Asynchronous SRAM: drives on OE low, captures while WE is low.
   assign ramData = (!ramOutputEnable && ramWriteEnable) ? sram[ramAddress] : 8'bz;
   always @(posedge clock) begin
      if (!ramWriteEnable) sram[ramAddress] <= ramData;
   end

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic next_cycle();
      @(negedge clock);
   endtask

   initial begin
      logic seen_complete;
      n_checks = 0;
      n_fail   = 0;
      resetN             = 1'b0;
      videoRequest       = 1'b0;
      videoAddress       = '0;
      memoryXCoord       = '0;
      memoryYCoord       = '0;
      memoryReadRequest  = 1'b0;
      memoryWriteRequest = 1'b0;
      memoryWriteData    = '0;
      sram[17'h00010] = 8'hA5;
      sram[17'h00020] = 8'h77;
      sram[17'h00100] = 8'h11;
      sram[17'h00200] = 8'h22;
      next_cycle();
      next_cycle();
      resetN = 1'b1;

      // Reset state
      check_output("reset_we", 32'(ramWriteEnable), 32'd1);
      check_output("reset_oe", 32'(ramOutputEnable), 32'd1);
      check_output("reset_addr", 32'(ramAddress), 32'd0);
      check_output("reset_vdata", 32'(videoData), 32'd0);
      check_output("reset_mdata", 32'(memoryReadData), 32'd0);
      check_output("reset_pulses", 32'({videoDataReady, videoOverrun, memoryReadComplete,
                   memoryWriteComplete, memoryRangeError}), 32'd0);

      // Video read of 0x00010
      videoRequest = 1'b1;
      videoAddress = 17'h00010;
      next_cycle();
      videoRequest = 1'b0;
      check_output("vread_oe_low1", 32'(ramOutputEnable), 32'd0);
      check_output("vread_addr", 32'(ramAddress), 32'h10);
      check_output("vread_we_high", 32'(ramWriteEnable), 32'd1);
      next_cycle();
      check_output("vread_oe_low2", 32'(ramOutputEnable), 32'd0);
      check_output("vread_not_ready", 32'(videoDataReady), 32'd0);
      next_cycle();
      check_output("vread_ready", 32'(videoDataReady), 32'd1);
      check_output("vread_data", 32'(videoData), 32'hA5);
      check_output("vread_oe_high", 32'(ramOutputEnable), 32'd1);
      next_cycle();
      check_output("vread_ready_pulse", 32'(videoDataReady), 32'd0);

      // MPU write x=5 y=3 -> 965
      memoryXCoord       = 9'd5;
      memoryYCoord       = 8'd3;
      memoryWriteData    = 8'h3C;
      memoryWriteRequest = 1'b1;
      next_cycle();
      check_output("mw_we_low1", 32'(ramWriteEnable), 32'd0);
      check_output("mw_addr", 32'(ramAddress), 32'd965);
      check_output("mw_data", 32'(ramData), 32'h3C);
      check_output("mw_oe_high", 32'(ramOutputEnable), 32'd1);
      next_cycle();
      check_output("mw_we_low2", 32'(ramWriteEnable), 32'd0);
      next_cycle();
      check_output("mw_recover_we", 32'(ramWriteEnable), 32'd1);
      check_output("mw_recover_data", 32'(ramData), 32'h3C);
      check_output("mw_no_early_complete", 32'(memoryWriteComplete), 32'd0);
      next_cycle();
      check_output("mw_complete", 32'(memoryWriteComplete), 32'd1);
      memoryWriteRequest = 1'b0;
      next_cycle();
      check_output("mw_complete_pulse", 32'(memoryWriteComplete), 32'd0);

      // Read back 965
      memoryReadRequest = 1'b1;
      next_cycle();
      check_output("mr_oe_low", 32'(ramOutputEnable), 32'd0);
      check_output("mr_addr", 32'(ramAddress), 32'd965);
      next_cycle();
      next_cycle();
      check_output("mr_complete", 32'(memoryReadComplete), 32'd1);
      check_output("mr_data", 32'(memoryReadData), 32'h3C);
      memoryReadRequest = 1'b0;
      next_cycle();

      // Simultaneous video and MPU read: video first, then MPU
      videoRequest      = 1'b1;
      videoAddress      = 17'h00020;
      memoryReadRequest = 1'b1;
      next_cycle();
      videoRequest = 1'b0;
      check_output("arb_video_addr", 32'(ramAddress), 32'h20);
      check_output("arb_video_oe", 32'(ramOutputEnable), 32'd0);
      next_cycle();
      next_cycle();
      check_output("arb_video_ready", 32'(videoDataReady), 32'd1);
      check_output("arb_video_data", 32'(videoData), 32'h77);
      check_output("arb_mpu_waiting", 32'(memoryReadComplete), 32'd0);
      next_cycle();
      check_output("arb_mpu_addr", 32'(ramAddress), 32'd965);
      check_output("arb_mpu_oe", 32'(ramOutputEnable), 32'd0);
      next_cycle();
      next_cycle();
      check_output("arb_mpu_complete", 32'(memoryReadComplete), 32'd1);
      check_output("arb_mpu_data", 32'(memoryReadData), 32'h3C);
      memoryReadRequest = 1'b0;
      next_cycle();

      // Range errors: read at x=320, then write at y=240
      memoryXCoord      = 9'd320;
      memoryYCoord      = 8'd0;
      memoryReadRequest = 1'b1;
      next_cycle();
      check_output("rerr_no_oe", 32'(ramOutputEnable), 32'd1);
      check_output("rerr_no_we", 32'(ramWriteEnable), 32'd1);
      next_cycle();
      check_output("rerr_range", 32'(memoryRangeError), 32'd1);
      check_output("rerr_complete", 32'(memoryReadComplete), 32'd1);
      check_output("rerr_data", 32'(memoryReadData), 32'h00);
      check_output("rerr_oe_still_high", 32'(ramOutputEnable), 32'd1);
      memoryReadRequest = 1'b0;
      next_cycle();
      memoryXCoord       = 9'd0;
      memoryYCoord       = 8'd240;
      memoryWriteData    = 8'hEE;
      memoryWriteRequest = 1'b1;
      next_cycle();
      check_output("werr_no_we", 32'(ramWriteEnable), 32'd1);
      next_cycle();
      check_output("werr_range", 32'(memoryRangeError), 32'd1);
      check_output("werr_complete", 32'(memoryWriteComplete), 32'd1);
      check_output("werr_no_we2", 32'(ramWriteEnable), 32'd1);
      memoryWriteRequest = 1'b0;
      next_cycle();
      check_output("werr_range_pulse", 32'(memoryRangeError), 32'd0);

      // Two video requests during an MPU write: overrun once, only 0x200 read
      memoryXCoord       = 9'd1;
      memoryYCoord       = 8'd0;
      memoryWriteData    = 8'h55;
      memoryWriteRequest = 1'b1;
      next_cycle();
      videoRequest = 1'b1;
      videoAddress = 17'h00100;
      #1;
      check_output("ovr_first_none", 32'(videoOverrun), 32'd0);
      next_cycle();
      videoAddress = 17'h00200;
      #1;
      check_output("ovr_second_pulse", 32'(videoOverrun), 32'd1);
      next_cycle();
      videoRequest = 1'b0;
      #1;
      check_output("ovr_cleared", 32'(videoOverrun), 32'd0);
      next_cycle();
      check_output("ovr_write_complete", 32'(memoryWriteComplete), 32'd1);
      memoryWriteRequest = 1'b0;
      next_cycle();
      check_output("ovr_read_addr", 32'(ramAddress), 32'h200);
      check_output("ovr_read_oe", 32'(ramOutputEnable), 32'd0);
      next_cycle();
      next_cycle();
      check_output("ovr_ready", 32'(videoDataReady), 32'd1);
      check_output("ovr_data", 32'(videoData), 32'h22);
      next_cycle();
      next_cycle();
      check_output("ovr_no_second_read", 32'({ramOutputEnable, videoDataReady}), 32'b10);

      // Reset in the middle of a write
      memoryXCoord       = 9'd2;
      memoryYCoord       = 8'd0;
      memoryWriteData    = 8'h99;
      memoryWriteRequest = 1'b1;
      next_cycle();
      check_output("rst_mid_we_low", 32'(ramWriteEnable), 32'd0);
      #1;
      resetN = 1'b0;
      #1;
      check_output("rst_mid_we_high", 32'(ramWriteEnable), 32'd1);
      check_output("rst_mid_oe_high", 32'(ramOutputEnable), 32'd1);
      memoryWriteRequest = 1'b0;
      next_cycle();
      resetN = 1'b1;
      seen_complete = 1'b0;
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         if (memoryWriteComplete) seen_complete = 1'b1;
      end
      check_output("rst_no_complete", 32'(seen_complete), 32'd0);
      check_output("rst_idle_we", 32'(ramWriteEnable), 32'd1);

      // After reset the arbiter accepts a fresh video read at full speed
      videoRequest = 1'b1;
      videoAddress = 17'h00010;
      next_cycle();
      videoRequest = 1'b0;
      check_output("post_rst_grant", 32'(ramOutputEnable), 32'd0);
      next_cycle();
      next_cycle();
      check_output("post_rst_ready", 32'(videoDataReady), 32'd1);
      check_output("post_rst_data", 32'(videoData), 32'hA5);
      next_cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
